// File: rtl/dot_field_controller.sv
// rtl/dot_field_controller.sv - pellet grid owner: per-frame hit scanner, score, power timer, pixel mask
module dot_field_controller #(
    parameter int COLS         = 4,
    parameter int ROWS         = 4,
    parameter int ORIGIN_X     = 64,
    parameter int ORIGIN_Y     = 64,
    parameter int PITCH_LOG2   = 5,
    parameter int DOT_SIZE     = 4,
    parameter int PAC_SIZE     = 16,
    parameter int HIT_RADIUS   = 4,
    parameter int DOT_POINTS   = 10,
    parameter int POWER_POINTS = 50,
    parameter int POWER_FRAMES = 120,
    parameter int POWER_EN     = 1,
    localparam int NUM_DOTS    = COLS * ROWS,
    localparam int CNT_W       = $clog2(NUM_DOTS + 1)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             frame_tick,
    input  logic             clr_dots,
    input  logic [9:0]       pac_X,
    input  logic [9:0]       pac_Y,
    input  logic [9:0]       DrawX,
    input  logic [9:0]       DrawY,
    output logic             dot_pixel,
    output logic             power_pixel,
    output logic [15:0]      score,
    output logic [CNT_W-1:0] dots_left,
    output logic             power_active,
    output logic             scan_busy,
    output logic             level_clear
);
    localparam int IDX_W = (NUM_DOTS > 1) ? $clog2(NUM_DOTS) : 1;
    localparam int TMR_W = $clog2(POWER_FRAMES + 1);
    localparam logic signed [11:0] HR = 12'(HIT_RADIUS);

    function automatic logic [NUM_DOTS-1:0] power_map();
        logic [NUM_DOTS-1:0] m;
        m = '0;
        if (POWER_EN != 0) begin
            m[0]             = 1'b1;
            m[COLS-1]        = 1'b1;
            m[NUM_DOTS-COLS] = 1'b1;
            m[NUM_DOTS-1]    = 1'b1;
        end
        return m;
    endfunction

    localparam logic [NUM_DOTS-1:0] POWER_MAP = power_map();

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d, col_q, col_d, row_q, row_d;
    logic [9:0]          pac_x_q, pac_x_d, pac_y_q, pac_y_d;
    logic [NUM_DOTS-1:0] eaten_q, eaten_d;
    logic [15:0]         score_q, score_d;
    logic [CNT_W-1:0]    dots_q, dots_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic                zero_q, zero_d;

    logic signed [11:0]  pac_cx, pac_cy, dot_cx, dot_cy, dx, dy;
    logic                hit, cur_power, take;
    logic [16:0]         score_sum;

    // 12-bit signed centres keep the differences free of wrap-around
    always_comb begin
        pac_cx = signed'({2'b00, pac_x_q} + 12'(PAC_SIZE / 2));
        pac_cy = signed'({2'b00, pac_y_q} + 12'(PAC_SIZE / 2));
        dot_cx = signed'(12'(ORIGIN_X + DOT_SIZE / 2) + (12'(col_q) << PITCH_LOG2));
        dot_cy = signed'(12'(ORIGIN_Y + DOT_SIZE / 2) + (12'(row_q) << PITCH_LOG2));
        dx     = pac_cx - dot_cx;
        dy     = pac_cy - dot_cy;
        hit    = (dx <= HR) && (dx >= -HR) && (dy <= HR) && (dy >= -HR);
        cur_power = POWER_MAP[idx_q];
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        col_d     = col_q;
        row_d     = row_q;
        pac_x_d   = pac_x_q;
        pac_y_d   = pac_y_q;
        eaten_d   = eaten_q;
        score_d   = score_q;
        dots_d    = dots_q;
        tmr_d     = tmr_q;
        zero_d    = zero_q;
        score_sum = '0;
        take      = (state_q == S_SCAN) && hit && !eaten_q[idx_q] && !clr_dots;

        if (frame_tick && (tmr_q != '0)) tmr_d = tmr_q - TMR_W'(1);

        case (state_q)
            S_IDLE: begin
                if (frame_tick) begin
                    state_d = S_SCAN;
                    idx_d   = '0;
                    col_d   = '0;
                    row_d   = '0;
                    pac_x_d = pac_X;
                    pac_y_d = pac_Y;
                    zero_d  = 1'b0;
                end
            end
            S_SCAN: begin
                if (idx_q == IDX_W'(NUM_DOTS - 1)) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                    if (col_q == IDX_W'(COLS - 1)) begin
                        col_d = '0;
                        row_d = row_q + IDX_W'(1);
                    end else begin
                        col_d = col_q + IDX_W'(1);
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (take) begin
            eaten_d[idx_q] = 1'b1;
            dots_d    = dots_q - CNT_W'(1);
            score_sum = {1'b0, score_q} + (cur_power ? 17'(POWER_POINTS) : 17'(DOT_POINTS));
            score_d   = score_sum[16] ? 16'hFFFF : score_sum[15:0];
            if (cur_power) tmr_d = TMR_W'(POWER_FRAMES);
            // remember that this scan is the one that emptied the field
            if (dots_q == CNT_W'(1)) zero_d = 1'b1;
        end

        if (clr_dots) begin
            eaten_d = '0;
            dots_d  = CNT_W'(NUM_DOTS);
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            pac_x_q <= '0;
            pac_y_q <= '0;
            eaten_q <= '0;
            score_q <= '0;
            dots_q  <= CNT_W'(NUM_DOTS);
            tmr_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            col_q   <= col_d;
            row_q   <= row_d;
            pac_x_q <= pac_x_d;
            pac_y_q <= pac_y_d;
            eaten_q <= eaten_d;
            score_q <= score_d;
            dots_q  <= dots_d;
            tmr_q   <= tmr_d;
            zero_q  <= zero_d;
        end
    end

    logic [11:0]      rx, ry, px_col, px_row;
    logic [IDX_W-1:0] px_idx;
    logic             in_dot;

    // pitch is a power of two, so cell and offset fall out of shifts and low bits
    always_comb begin
        rx     = {2'b00, DrawX} - 12'(ORIGIN_X);
        ry     = {2'b00, DrawY} - 12'(ORIGIN_Y);
        px_col = rx >> PITCH_LOG2;
        px_row = ry >> PITCH_LOG2;
        in_dot = !rx[11] && !ry[11]
              && (px_col < 12'(COLS)) && (px_row < 12'(ROWS))
              && (rx[PITCH_LOG2-1:0] < PITCH_LOG2'(DOT_SIZE))
              && (ry[PITCH_LOG2-1:0] < PITCH_LOG2'(DOT_SIZE));
        px_idx = IDX_W'(px_row * 12'(COLS) + px_col);
        dot_pixel   = in_dot && !eaten_q[px_idx] && !POWER_MAP[px_idx];
        power_pixel = in_dot && !eaten_q[px_idx] &&  POWER_MAP[px_idx];
    end

    assign score        = score_q;
    assign dots_left    = dots_q;
    assign power_active = (tmr_q != '0);
    assign scan_busy    = (state_q == S_SCAN);
    assign level_clear  = (state_q == S_DONE) && (dots_q == '0) && zero_q;
endmodule

// File: tb/tb_dot_field_controller.sv
// tb/tb_dot_field_controller.sv - scoreboard bench for dot_field_controller
module tb_dot_field_controller;
    logic       Clk = 1'b0;
    logic       Reset, frame_tick, clr_dots;
    logic [9:0] pac_X, pac_Y, DrawX, DrawY;
    logic       dot_pixel, power_pixel, power_active, scan_busy, level_clear;
    logic [15:0] score;
    logic [4:0]  dots_left;

    dot_field_controller dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .clr_dots(clr_dots),
        .pac_X(pac_X), .pac_Y(pac_Y), .DrawX(DrawX), .DrawY(DrawY),
        .dot_pixel(dot_pixel), .power_pixel(power_pixel), .score(score),
        .dots_left(dots_left), .power_active(power_active), .scan_busy(scan_busy),
        .level_clear(level_clear)
    );

    always #5 Clk = ~Clk;

    typedef struct { int score; int dots; bit lc; bit pa; } scan_exp_t;
    typedef struct { bit dot; bit pow; int score; int dots; bit pa; bit busy; } probe_exp_t;

    scan_exp_t  scan_q[$];
    probe_exp_t probe_q[$];
    scan_exp_t  se;
    probe_exp_t pe;
    int compared = 0, mismatched = 0;
    int done_cnt = 0, lc_count = 0, busy_len = 0;
    bit prev_busy = 0, prev_abort = 0, probe_req = 0;
    int sc, dl;

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // monitor: a busy fall not preceded by reset/clr is a scan completion
    always @(negedge Clk) begin
        if (level_clear) lc_count++;
        if (scan_busy) begin
            busy_len++;
        end else begin
            if (prev_busy && !prev_abort) begin
                if (scan_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_done: got scan completion expected none (t=%0t)", $time);
                end else begin
                    se = scan_q.pop_front();
                    check("done_score", int'(score), se.score);
                    check("done_dots_left", int'(dots_left), se.dots);
                    check("done_level_clear", int'(level_clear), int'(se.lc));
                    check("done_power_active", int'(power_active), int'(se.pa));
                    check("scan_len", busy_len, 16);
                end
                done_cnt++;
            end
            busy_len = 0;
        end
        if (probe_req && probe_q.size() != 0) begin
            pe = probe_q.pop_front();
            check("probe_dot_pixel", int'(dot_pixel), int'(pe.dot));
            check("probe_power_pixel", int'(power_pixel), int'(pe.pow));
            check("probe_score", int'(score), pe.score);
            check("probe_dots_left", int'(dots_left), pe.dots);
            check("probe_power_active", int'(power_active), int'(pe.pa));
            check("probe_scan_busy", int'(scan_busy), int'(pe.busy));
        end
        prev_busy  = scan_busy;
        prev_abort = Reset || clr_dots;
    end

    task automatic probe(input int x, input int y, input bit ed, input bit ep,
                         input int es, input int edl, input bit epa, input bit eb);
        probe_exp_t p;
        p.dot = ed; p.pow = ep; p.score = es; p.dots = edl; p.pa = epa; p.busy = eb;
        probe_q.push_back(p);
        DrawX = 10'(x);
        DrawY = 10'(y);
        probe_req = 1'b1;
        @(posedge Clk); #1;
        probe_req = 1'b0;
    endtask

    task automatic do_scan(input int px, input int py, input int es, input int ed,
                           input bit elc, input bit epa, input int extra_tick);
        scan_exp_t e;
        int start;
        e.score = es; e.dots = ed; e.lc = elc; e.pa = epa;
        scan_q.push_back(e);
        start = done_cnt;
        pac_X = 10'(px);
        pac_Y = 10'(py);
        frame_tick = 1'b1;
        @(posedge Clk); #1;
        frame_tick = 1'b0;
        if (extra_tick >= 0) begin
            repeat (extra_tick) @(posedge Clk);
            #1 frame_tick = 1'b1;
            @(posedge Clk); #1;
            frame_tick = 1'b0;
        end
        for (int n = 0; n < 100 && done_cnt == start; n++) @(posedge Clk);
        #1;
        if (done_cnt == start) begin
            compared++;
            mismatched++;
            $display("FAIL scan_timeout: got no completion expected one within 100 cycles");
            scan_q.delete();
        end
    endtask

    task automatic pulse_reset();
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; frame_tick = 1'b0; clr_dots = 1'b0;
        pac_X = '0; pac_Y = '0; DrawX = '0; DrawY = '0;
        repeat (3) @(posedge Clk);
        #1 Reset = 1'b0;

        // reset state and pixel mask
        probe(64, 64, 0, 1, 0, 16, 0, 0);
        probe(96, 64, 1, 0, 0, 16, 0, 0);
        probe(68, 64, 0, 0, 0, 16, 0, 0);

        // normal pellet 1, then a repeat scan scores nothing
        do_scan(90, 58, 10, 15, 0, 0, -1);
        probe(96, 64, 0, 0, 10, 15, 0, 0);
        do_scan(90, 58, 10, 15, 0, 0, -1);

        // power pellet 0 and timer run-down
        do_scan(58, 58, 60, 14, 0, 1, -1);
        for (int k = 1; k <= 120; k++) do_scan(0, 0, 60, 14, 0, (k < 120), -1);
        do_scan(154, 58, 110, 13, 0, 1, -1);
        for (int k = 1; k <= 119; k++) do_scan(0, 0, 110, 13, 0, 1, -1);
        // timer is 1 here: the tick empties it, the pellet-12 hit reloads it
        do_scan(58, 154, 160, 12, 0, 1, -1);
        do_scan(0, 0, 160, 12, 0, 1, -1);

        // hit radius boundaries
        pulse_reset();
        probe(0, 0, 0, 0, 0, 16, 0, 0);
        do_scan(95, 58, 0, 16, 0, 0, -1);
        do_scan(94, 58, 10, 15, 0, 0, -1);
        do_scan(117, 58, 10, 15, 0, 0, -1);
        do_scan(118, 58, 20, 14, 0, 0, -1);
        do_scan(90, 95, 20, 14, 0, 0, -1);
        do_scan(90, 94, 30, 13, 0, 0, -1);

        // eat the remaining pellets
        sc = 30; dl = 13;
        for (int i = 0; i < 16; i++) begin
            if (i != 1 && i != 2 && i != 5) begin
                sc += (i == 0 || i == 3 || i == 12 || i == 15) ? 50 : 10;
                dl--;
                do_scan(58 + 32 * (i % 4), 58 + 32 * (i / 4), sc, dl, (dl == 0), 1, -1);
            end
        end
        do_scan(0, 0, 320, 0, 0, 1, -1);
        clr_dots = 1'b1;
        @(posedge Clk); #1;
        clr_dots = 1'b0;
        probe(64, 64, 0, 1, 320, 16, 1, 0);
        probe(96, 64, 1, 0, 320, 16, 1, 0);

        // reset in the middle of a scan that has already scored
        pac_X = 10'd58; pac_Y = 10'd58;
        frame_tick = 1'b1;
        @(posedge Clk); #1;
        frame_tick = 1'b0;
        repeat (5) @(posedge Clk);
        #1 pulse_reset();
        repeat (25) @(posedge Clk);
        #1 probe(64, 64, 0, 1, 0, 16, 0, 0);

        // frame_tick during a scan is dropped
        do_scan(0, 0, 0, 16, 0, 0, 4);
        repeat (20) @(posedge Clk);
        #1 probe(0, 0, 0, 0, 0, 16, 0, 0);

        // clr_dots on the cycle pellet 0 would be hit
        do_scan(90, 58, 10, 15, 0, 0, -1);
        pac_X = 10'd58; pac_Y = 10'd58;
        frame_tick = 1'b1;
        @(posedge Clk); #1;
        frame_tick = 1'b0;
        clr_dots = 1'b1;
        @(posedge Clk); #1;
        clr_dots = 1'b0;
        repeat (20) @(posedge Clk);
        #1 probe(96, 64, 1, 0, 10, 16, 0, 0);
        probe(64, 64, 0, 1, 10, 16, 0, 0);

        check("level_clear_pulses", lc_count, 1);
        check("scan_queue_drained", scan_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
